// File: rtl/pad_gpio_pkg.sv
// ---------------------------------------------------------------------------
// pad_gpio_pkg
// Shared definitions for the pad GPIO controller: register addresses on the
// write port, the direction-turnaround FSM encoding and the drive-config
// reset value.
// ---------------------------------------------------------------------------
package pad_gpio_pkg;

  // Write-port register map
  localparam logic [1:0] ADDR_OUT    = 2'd0;
  localparam logic [1:0] ADDR_DIR    = 2'd1;
  localparam logic [1:0] ADDR_DRV    = 2'd2;
  localparam logic [1:0] ADDR_IEMASK = 2'd3;

  // {sr, ds1, ds0} after reset
  localparam logic [2:0] DRV_RST = 3'b001;

  // Direction turnaround sequencer
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    APPLY = 2'd2
  } fsm_e;

endpackage

// File: rtl/pad_gpio_sync.sv
// ---------------------------------------------------------------------------
// pad_gpio_sync
// One-pin receive path: two-flop synchronizer for the asynchronous pad Y
// value, optional debounce filter, and input-enable masking.
//
// Configuration macro: GPIO_PAD_DEBOUNCE_EN
//   defined   : output follows the synced bit only after it has held a new
//               value for DB_CYC consecutive cycles (latency 2 + DB_CYC)
//   undefined : output is the synced bit directly (latency 2)
//
// Ports
//   clk   in  1  clock
//   rstn  in  1  synchronous reset, active low
//   i_d   in  1  raw pad receive value (asynchronous)
//   i_en  in  1  pad input enable; output forced to 0 when low
//   o_q   out 1  synchronized (optionally debounced) masked value
// ---------------------------------------------------------------------------
module pad_gpio_sync #(
  parameter int DB_CYC = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  input  logic i_en,
  output logic o_q
);

  if (DB_CYC < 2) begin : g_bad_db_cyc
    $error("pad_gpio_sync: DB_CYC must be >= 2");
  end

  logic r_s1;
  logic r_s2;

  // NOTE: every flop here is reset synchronously (rstn sampled on the clock
  // edge, not in the sensitivity list), and sequential state is always
  // updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYC);

  logic [CW-1:0] r_cnt;
  logic          r_q;

  // r_cnt counts consecutive cycles the synced bit has disagreed with r_q;
  // any return to the accepted value restarts the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
    end else if (r_s2 == r_q) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DB_CYC - 1)) begin
      r_q   <= r_s2;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_q = r_q & i_en;
`else
  assign o_q = r_s2 & i_en;
`endif

endmodule

// File: rtl/pad_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// pad_gpio_ctrl
// Core-side controller for a bank of NPINS bidirectional pads. Holds the
// output value, direction, input-enable mask and shared drive config,
// written through a valid/ready port. Direction changes go through a
// turnaround sequence (changing pins have OE=0 and IE=0 for TURN_CYC
// cycles before the new direction is applied) so OE and IE are never set
// together on any pin. Receive values come back synchronized with a change
// pulse for interrupt logic.
//
// Configuration macro: GPIO_PAD_DEBOUNCE_EN (per-pin debounce, see
// pad_gpio_sync).
//
// Ports
//   clk          in   1      clock
//   rstn         in   1      synchronous reset, active low
//   wr_valid     in   1      register write request
//   wr_ready     out  1      write accepted when wr_valid && wr_ready
//   wr_addr      in   2      0=OUT 1=DIR 2=DRV 3=IEMASK
//   wr_data      in   NPINS  write data (DRV uses [2:0] = {SR,DS1,DS0})
//   pad_a        out  NPINS  pad output value
//   pad_oe       out  NPINS  pad output enable
//   pad_ie       out  NPINS  pad input enable
//   pad_ds0      out  1      drive strength bit 0
//   pad_ds1      out  1      drive strength bit 1
//   pad_sr       out  1      slew rate
//   pad_y        in   NPINS  pad receive value (asynchronous)
//   gpio_in      out  NPINS  synchronized input value
//   gpio_in_chg  out  1      one-cycle pulse after gpio_in changes
//   busy         out  1      direction turnaround in progress
// ---------------------------------------------------------------------------
module pad_gpio_ctrl
  import pad_gpio_pkg::*;
#(
  parameter int NPINS    = 8,
  parameter int TURN_CYC = 2,
  parameter int DB_CYC   = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_addr,
  input  logic [NPINS-1:0] wr_data,
  output logic [NPINS-1:0] pad_a,
  output logic [NPINS-1:0] pad_oe,
  output logic [NPINS-1:0] pad_ie,
  output logic             pad_ds0,
  output logic             pad_ds1,
  output logic             pad_sr,
  input  logic [NPINS-1:0] pad_y,
  output logic [NPINS-1:0] gpio_in,
  output logic             gpio_in_chg,
  output logic             busy
);

  if (NPINS < 3) begin : g_bad_npins
    $error("pad_gpio_ctrl: NPINS must be >= 3");
  end
  if (TURN_CYC < 1) begin : g_bad_turn_cyc
    $error("pad_gpio_ctrl: TURN_CYC must be >= 1");
  end

  localparam int CNT_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  fsm_e             r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [NPINS-1:0] r_out;
  logic [NPINS-1:0] r_dir;
  logic [NPINS-1:0] r_oe;
  logic [NPINS-1:0] r_ie;
  logic [NPINS-1:0] r_ie_mask;
  logic [NPINS-1:0] r_m;        // pins changing direction in this turnaround
  logic [2:0]       r_drv;      // {sr, ds1, ds0}
  logic             r_wr_ready;
  logic             r_busy;
  logic [NPINS-1:0] r_gpio_prev;
  logic             r_chg;

  logic             w_wr_fire;
  logic [NPINS-1:0] w_m;
  logic [NPINS-1:0] w_gpio_in;

  assign w_wr_fire = wr_valid & r_wr_ready;
  assign w_m       = wr_data ^ r_dir;

  // Register file and turnaround sequencer. wr_ready/busy are registered
  // alongside the state so they change on the same edge as r_state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_out      <= '0;
      r_dir      <= '0;
      r_oe       <= '0;
      r_ie       <= '1;
      r_ie_mask  <= '1;
      r_m        <= '0;
      r_drv      <= DRV_RST;
      r_wr_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_fire) begin
            case (wr_addr)
              ADDR_OUT: r_out <= wr_data;
              ADDR_DRV: r_drv <= wr_data[2:0];
              ADDR_IEMASK: begin
                // Outputs keep IE off regardless of the mask.
                r_ie_mask <= wr_data;
                r_ie      <= wr_data & ~r_dir;
              end
              ADDR_DIR: begin
                // Rewriting the current direction is a no-op; otherwise
                // silence only the changing pins and start the quiet period.
                if (w_m != '0) begin
                  r_dir      <= wr_data;
                  r_m        <= w_m;
                  r_oe       <= r_oe & ~w_m;
                  r_ie       <= r_ie & ~w_m;
                  r_cnt      <= '0;
                  r_state    <= TURN;
                  r_busy     <= 1'b1;
                  r_wr_ready <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
        TURN: begin
          if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
            r_state <= APPLY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        APPLY: begin
          r_oe       <= r_oe | (r_dir & r_m);
          r_ie       <= r_ie | (~r_dir & r_m & r_ie_mask);
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    pad_gpio_sync #(
      .DB_CYC (DB_CYC)
    ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .i_d  (pad_y[i]),
      .i_en (r_ie[i]),
      .o_q  (w_gpio_in[i])
    );
  end

  // Change pulse lags gpio_in by one cycle and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_gpio_prev <= '0;
      r_chg       <= 1'b0;
    end else begin
      r_gpio_prev <= w_gpio_in;
      r_chg       <= (w_gpio_in != r_gpio_prev);
    end
  end

  assign wr_ready    = r_wr_ready;
  assign busy        = r_busy;
  assign pad_a       = r_out;
  assign pad_oe      = r_oe;
  assign pad_ie      = r_ie;
  assign pad_sr      = r_drv[2];
  assign pad_ds1     = r_drv[1];
  assign pad_ds0     = r_drv[0];
  assign gpio_in     = w_gpio_in;
  assign gpio_in_chg = r_chg;

endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pad_gpio_ctrl
// Scoreboard bench for pad_gpio_ctrl (NPINS=8, TURN_CYC=2, DB_CYC=4).
// Stimulus pushes hand-computed expectations tagged with the cycle they
// must hold in; a monitor on the falling edge pops and compares them,
// checks the OE/IE exclusion every cycle, and matches each gpio_in_chg
// pulse against a queue of expected gpio_in values.
// ---------------------------------------------------------------------------
module tb_pad_gpio_ctrl;
  import pad_gpio_pkg::*;

`ifdef GPIO_PAD_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  typedef enum {S_A, S_OE, S_IE, S_DRV, S_GIN, S_BUSY, S_RDY, S_CHG} sig_e;
  typedef struct {
    int         cyc;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       wr_valid;
  logic       wr_ready;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] pad_a, pad_oe, pad_ie, pad_y, gpio_in;
  logic       pad_ds0, pad_ds1, pad_sr;
  logic       gpio_in_chg, busy;

  exp_t       sb_q[$];
  logic [7:0] chg_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;

  pad_gpio_ctrl #(
    .NPINS    (8),
    .TURN_CYC (2),
    .DB_CYC   (4)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pad_a       (pad_a),
    .pad_oe      (pad_oe),
    .pad_ie      (pad_ie),
    .pad_ds0     (pad_ds0),
    .pad_ds1     (pad_ds1),
    .pad_sr      (pad_sr),
    .pad_y       (pad_y),
    .gpio_in     (gpio_in),
    .gpio_in_chg (gpio_in_chg),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] probe(sig_e s);
    case (s)
      S_A:     return pad_a;
      S_OE:    return pad_oe;
      S_IE:    return pad_ie;
      S_DRV:   return {5'b0, pad_sr, pad_ds1, pad_ds0};
      S_GIN:   return gpio_in;
      S_BUSY:  return {7'b0, busy};
      S_RDY:   return {7'b0, wr_ready};
      S_CHG:   return {7'b0, gpio_in_chg};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: compares everything due this cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    logic [7:0] e;
    if (mon_en) begin
      checks++;
      if ((pad_oe & pad_ie) !== 8'h00) begin
        errors++;
        $display("FAIL oe_ie_overlap cyc=%0d oe=%h ie=%h required_and=00", cyc, pad_oe, pad_ie);
      end
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].cyc <= cyc) begin
          act = probe(sb_q[i].sig);
          checks++;
          if (sb_q[i].cyc < cyc || act !== sb_q[i].val) begin
            errors++;
            $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h",
                     sb_q[i].sig.name(), cyc, sb_q[i].cyc, act, sb_q[i].val);
          end
          sb_q.delete(i);
        end
      end
      if (gpio_in_chg === 1'b1) begin
        checks++;
        if (chg_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_chg cyc=%0d gpio_in=%h exp=no_pulse", cyc, gpio_in);
        end else begin
          e = chg_q.pop_front();
          if (gpio_in !== e) begin
            errors++;
            $display("FAIL chg_value cyc=%0d got=%h exp=%h", cyc, gpio_in, e);
          end
        end
      end
    end
  end

  task automatic exp_at(input int dc, input sig_e s, input logic [7:0] v);
    exp_t t;
    t.cyc = cyc + dc;
    t.sig = s;
    t.val = v;
    sb_q.push_back(t);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Present a write and return at the falling edge just before the
  // accepting rising edge (wr_ready seen high, wr_valid still driven).
  task automatic wr_issue(input logic [1:0] a, input logic [7:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    for (int k = 0; k < 50 && wr_ready !== 1'b1; k++) step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept_timeout cyc=%0d wr_ready=%b exp=1", cyc, wr_ready);
    end
  endtask

  task automatic wr_end();
    step();
    wr_valid = 1'b0;
  endtask

  task automatic exp_reset_state(input int dc);
    exp_at(dc, S_A,    8'h00);
    exp_at(dc, S_OE,   8'h00);
    exp_at(dc, S_IE,   8'hFF);
    exp_at(dc, S_DRV,  8'h01);
    exp_at(dc, S_GIN,  8'h00);
    exp_at(dc, S_BUSY, 8'h00);
    exp_at(dc, S_RDY,  8'h01);
    exp_at(dc, S_CHG,  8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rstn     = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 8'h00;
    pad_y    = 8'h00;
    step(2);
    mon_en = 1'b1;
    rstn   = 1'b1;
    exp_reset_state(1);
    exp_reset_state(2);
    step(3);

    // OUT write: pad_a follows, OE untouched
    wr_issue(ADDR_OUT, 8'hA5);
    exp_at(1, S_A,  8'hA5);
    exp_at(1, S_OE, 8'h00);
    wr_end();
    step();

    // DIR=0F turnaround, with an OUT write held off until IDLE
    wr_issue(ADDR_DIR, 8'h0F);
    t0 = cyc;
    exp_at(1, S_IE,   8'hF0);
    exp_at(1, S_OE,   8'h00);
    exp_at(1, S_BUSY, 8'h01);
    exp_at(1, S_RDY,  8'h00);
    exp_at(2, S_BUSY, 8'h01);
    exp_at(2, S_OE,   8'h00);
    exp_at(3, S_BUSY, 8'h01);
    exp_at(3, S_OE,   8'h00);
    exp_at(3, S_IE,   8'hF0);
    exp_at(3, S_A,    8'hA5);
    exp_at(4, S_OE,   8'h0F);
    exp_at(4, S_IE,   8'hF0);
    exp_at(4, S_BUSY, 8'h00);
    exp_at(4, S_RDY,  8'h01);
    exp_at(4, S_A,    8'hA5);
    exp_at(5, S_A,    8'h5A);
    wr_end();
    wr_issue(ADDR_OUT, 8'h5A);
    checks++;
    if (cyc != t0 + 4) begin
      errors++;
      $display("FAIL held_write_accept got_cyc=%0d exp_cyc=%0d", cyc - t0, 4);
    end
    wr_end();
    step();

    // Same direction again: no turnaround
    wr_issue(ADDR_DIR, 8'h0F);
    exp_at(1, S_BUSY, 8'h00);
    exp_at(1, S_RDY,  8'h01);
    exp_at(1, S_OE,   8'h0F);
    exp_at(1, S_IE,   8'hF0);
    wr_end();

    // DIR=03: pins 2,3 go quiet then become inputs
    wr_issue(ADDR_DIR, 8'h03);
    exp_at(1, S_OE,   8'h03);
    exp_at(1, S_IE,   8'hF0);
    exp_at(2, S_IE,   8'hF0);
    exp_at(3, S_OE,   8'h03);
    exp_at(3, S_IE,   8'hF0);
    exp_at(4, S_OE,   8'h03);
    exp_at(4, S_IE,   8'hFC);
    exp_at(4, S_BUSY, 8'h00);
    wr_end();
    step(4);

    // Drive config: only wr_data[2:0] is used
    wr_issue(ADDR_DRV, 8'h06);
    exp_at(1, S_DRV, 8'h06);
    wr_end();
    wr_issue(ADDR_DRV, 8'hFB);
    exp_at(1, S_DRV, 8'h03);
    wr_end();

    // IEMASK clears pin 3; outputs stay IE=0
    wr_issue(ADDR_IEMASK, 8'hF7);
    exp_at(1, S_IE, 8'hF4);
    wr_end();

    // DIR=01: pin 1 turns into an input
    wr_issue(ADDR_DIR, 8'h01);
    exp_at(1, S_OE, 8'h01);
    exp_at(1, S_IE, 8'hF4);
    exp_at(4, S_OE, 8'h01);
    exp_at(4, S_IE, 8'hF6);
    wr_end();
    step(4);

    // Input path: rising edge on pin 7
    pad_y = 8'h80;
    exp_at(LAT - 1, S_GIN, 8'h00);
    exp_at(LAT,     S_GIN, 8'h80);
    exp_at(LAT,     S_CHG, 8'h00);
    exp_at(LAT + 1, S_CHG, 8'h01);
    exp_at(LAT + 2, S_CHG, 8'h00);
    chg_q.push_back(8'h80);
    step(LAT + 4);

    // Falling edge on pin 7
    pad_y = 8'h00;
    exp_at(LAT - 1, S_GIN, 8'h80);
    exp_at(LAT,     S_GIN, 8'h00);
    exp_at(LAT + 1, S_CHG, 8'h01);
    chg_q.push_back(8'h00);
    step(LAT + 4);

    // Masked pin 3 never reaches gpio_in
    pad_y = 8'h08;
    exp_at(LAT + 1, S_GIN, 8'h00);
    step(LAT + 3);
    pad_y = 8'h00;
    step(LAT + 3);

`ifdef GPIO_PAD_DEBOUNCE_EN
    // Two-cycle glitch is filtered out
    pad_y = 8'h80;
    step(2);
    pad_y = 8'h00;
    exp_at(LAT - 1, S_GIN, 8'h00);
    exp_at(LAT + 2, S_GIN, 8'h00);
    step(LAT + 6);
`endif

    // Reset in the middle of a turnaround aborts it
    wr_issue(ADDR_DIR, 8'h00);
    exp_at(1, S_BUSY, 8'h01);
    exp_at(1, S_IE,   8'hF6);
    wr_end();
    rstn = 1'b0;
    exp_reset_state(1);
    step();
    rstn = 1'b1;
    exp_at(3, S_OE,   8'h00);
    exp_at(3, S_IE,   8'hFF);
    exp_at(3, S_BUSY, 8'h00);
    step(4);

    // IEMASK=00: pad activity is invisible
    wr_issue(ADDR_IEMASK, 8'h00);
    exp_at(1, S_IE, 8'h00);
    wr_end();
    pad_y = 8'hFF;
    exp_at(LAT + 1, S_GIN, 8'h00);
    step(3);
    pad_y = 8'h00;
    step(2);
    pad_y = 8'hA5;
    exp_at(LAT + 1, S_GIN, 8'h00);
    exp_at(LAT + 3, S_GIN, 8'h00);
    step(LAT + 4);
    pad_y = 8'h00;
    step(LAT + 4);

    step(5);
    foreach (sb_q[i]) begin
      checks++;
      errors++;
      $display("FAIL never_checked %s due=%0d exp=%h", sb_q[i].sig.name(), sb_q[i].cyc, sb_q[i].val);
    end
    foreach (chg_q[i]) begin
      checks++;
      errors++;
      $display("FAIL missing_chg got=no_pulse exp=%h", chg_q[i]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
